// File: rtl/f100l_bus_pkg.sv
// rtl/f100l_bus_pkg.sv - shared F100-L memory bus definitions: bank encodings, bank-select field, DMA states
package f100l_bus_pkg;

    localparam logic [1:0] BANK_RAM       = 2'b00;
    localparam logic [1:0] BANK_ROM       = 2'b01;
    localparam logic [1:0] BANK_PERIPH    = 2'b10;
    localparam logic [1:0] BANK_BLOCK_RAM = 2'b11;

    localparam int BANK_SEL_HI = 14;
    localparam int BANK_SEL_LO = 13;

    localparam int COUNT_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQUEST = 3'd1,
        ST_READ    = 3'd2,
        ST_WRITE   = 3'd3,
        ST_NEXT    = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERROR   = 3'd6
    } dma_state_t;

endpackage

// File: rtl/memory_bus_dma.sv
// rtl/memory_bus_dma.sv - block-copy DMA initiator; define MEMORY_BUS_DMA_ROM_GUARD_EN to abort on ROM-bank writes
module memory_bus_dma
    import f100l_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  src_addr,
    input  logic [ADDR_WIDTH-1:0]  dst_addr,
    input  logic [COUNT_WIDTH-1:0] count,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic                   bus_request,
    input  logic                   bus_grant,
    output logic [ADDR_WIDTH-1:0]  address,
    output logic [DATA_WIDTH-1:0]  bus_data_out,
    input  logic [DATA_WIDTH-1:0]  bus_data_in,
    output logic                   bus_enable,
    output logic                   write_enable,
    input  logic                   bus_ready
);

    dma_state_t             state;
    logic [ADDR_WIDTH-1:0]  src;
    logic [ADDR_WIDTH-1:0]  dst;
    logic [COUNT_WIDTH-1:0] remaining;
    logic [DATA_WIDTH-1:0]  data_hold;

    // The held read word is the write data; it is already a register, so the output stays registered.
    assign bus_data_out = data_hold;

    // Copy sequencer: every output is set on the edge that enters the state it belongs to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            src          <= '0;
            dst          <= '0;
            remaining    <= '0;
            data_hold    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            bus_request  <= 1'b0;
            address      <= '0;
            bus_enable   <= 1'b0;
            write_enable <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        src       <= src_addr;
                        dst       <= dst_addr;
                        remaining <= count;
                        if (count == '0) begin
                            // Empty copy completes at once and never claims the bus.
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state       <= ST_REQUEST;
                            busy        <= 1'b1;
                            bus_request <= 1'b1;
                        end
                    end
                end
                ST_REQUEST: begin
                    if (bus_grant) begin
                        state      <= ST_READ;
                        address    <= src;
                        bus_enable <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (bus_ready) begin
                        data_hold <= bus_data_in;
`ifdef MEMORY_BUS_DMA_ROM_GUARD_EN
                        if (dst[BANK_SEL_HI:BANK_SEL_LO] == BANK_ROM) begin
                            // Refuse the write before the strobe is ever raised.
                            state       <= ST_ERROR;
                            error       <= 1'b1;
                            bus_enable  <= 1'b0;
                            bus_request <= 1'b0;
                        end else begin
                            state        <= ST_WRITE;
                            address      <= dst;
                            write_enable <= 1'b1;
                        end
`else
                        state        <= ST_WRITE;
                        address      <= dst;
                        write_enable <= 1'b1;
`endif
                    end
                end
                ST_WRITE: begin
                    if (bus_ready) begin
                        state        <= ST_NEXT;
                        bus_enable   <= 1'b0;
                        write_enable <= 1'b0;
                    end
                end
                ST_NEXT: begin
                    src       <= src + ADDR_WIDTH'(1);
                    dst       <= dst + ADDR_WIDTH'(1);
                    remaining <= remaining - COUNT_WIDTH'(1);
                    if (remaining == COUNT_WIDTH'(1)) begin
                        state       <= ST_DONE;
                        done        <= 1'b1;
                        bus_request <= 1'b0;
                    end else if (bus_grant) begin
                        state      <= ST_READ;
                        address    <= src + ADDR_WIDTH'(1);
                        bus_enable <= 1'b1;
                    end else begin
                        // Grant withdrawn between words: keep requesting and wait.
                        state <= ST_REQUEST;
                    end
                end
                ST_DONE, ST_ERROR: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_bus_dma.sv
// tb/tb_memory_bus_dma.sv - directed vector bench for memory_bus_dma with a word-addressed memory model
module tb_memory_bus_dma;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic        error;
    logic        bus_request;
    logic        bus_grant;
    logic [15:0] address;
    logic [15:0] bus_data_out;
    logic [15:0] bus_data_in;
    logic        bus_enable;
    logic        write_enable;
    logic        bus_ready;

    logic [15:0] mem [0:65535];

    int tests;
    int fails;

    memory_bus_dma #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .count        (count),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .bus_request  (bus_request),
        .bus_grant    (bus_grant),
        .address      (address),
        .bus_data_out (bus_data_out),
        .bus_data_in  (bus_data_in),
        .bus_enable   (bus_enable),
        .write_enable (write_enable),
        .bus_ready    (bus_ready)
    );

    assign bus_data_in = mem[address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] cnt;
        int          r_from;
        int          r_to;
        int          g_from;
        int          g_to;
        int          chk_cyc;
        logic [15:0] chk_addr;
        int          done_cyc;
        int          err_cyc;
        int          busy_cyc;
        int          en_cyc;
        int          wr_cnt;
        int          req_cyc;
        bit          data_chk;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] w2;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int done_c, err_c, busy_c, en_c, wr_c, req_c, en_nogrant, we_alone;
        logic [15:0] got_addr;
        logic [15:0] exp_w [3];
        done_c = 0; err_c = 0; busy_c = 0; en_c = 0; wr_c = 0; req_c = 0;
        en_nogrant = 0; we_alone = 0; got_addr = 16'hxxxx;
        exp_w[0] = v.w0; exp_w[1] = v.w1; exp_w[2] = v.w2;

        @(negedge clk);
        src_addr = v.src; dst_addr = v.dst; count = v.cnt; start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start     = 1'b0;
            bus_grant = !(v.g_from != 0 && k >= v.g_from && k <= v.g_to);
            bus_ready = !(v.r_from != 0 && k >= v.r_from && k <= v.r_to);
            if (done && done_c == 0) done_c = k;
            if (error && err_c == 0) err_c = k;
            busy_c += int'(busy);
            en_c   += int'(bus_enable);
            req_c  += int'(bus_request);
            if (bus_enable && !bus_grant) en_nogrant++;
            if (write_enable && !bus_enable) we_alone++;
            if (k == v.chk_cyc) got_addr = address;
            if (bus_enable && write_enable && bus_ready) begin
                wr_c++;
                if (address[14:13] != 2'b01) mem[address] = bus_data_out;
            end
        end
        bus_grant = 1'b1;
        bus_ready = 1'b1;

        check($sformatf("v%0d done_cycle", n), done_c, v.done_cyc);
        check($sformatf("v%0d error_cycle", n), err_c, v.err_cyc);
        check($sformatf("v%0d busy_cycles", n), busy_c, v.busy_cyc);
        check($sformatf("v%0d enable_cycles", n), en_c, v.en_cyc);
        check($sformatf("v%0d write_strobes", n), wr_c, v.wr_cnt);
        check($sformatf("v%0d request_cycles", n), req_c, v.req_cyc);
        check($sformatf("v%0d enable_without_grant", n), en_nogrant, 0);
        check($sformatf("v%0d we_without_enable", n), we_alone, 0);
        if (v.chk_cyc != 0)
            check($sformatf("v%0d address_at_cycle_%0d", n, v.chk_cyc), got_addr, v.chk_addr);
        if (v.data_chk) begin
            for (int i = 0; i < int'(v.cnt) && i < 3; i++)
                check($sformatf("v%0d dst_word_%0d", n, i), mem[16'(v.dst + 16'(i))], exp_w[i]);
        end
    endtask

    initial begin
        int dc, ec;
        tests = 0;
        fails = 0;
        reset = 1'b0;
        start = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        count = '0;
        bus_grant = 1'b1;
        bus_ready = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0000] = 16'h1111; mem[16'h0001] = 16'h2222; mem[16'h0002] = 16'h3333;
        mem[16'h0010] = 16'hAAAA; mem[16'h0011] = 16'hBBBB; mem[16'h0012] = 16'hCCCC;
        mem[16'h0020] = 16'h5A5A; mem[16'h0021] = 16'hA5A5;
        mem[16'hFFFF] = 16'hBEEF;

        //             src      dst      cnt  rf rt gf gt chk addr     done err busy en wr req data w0        w1        w2
        vecs[0] = '{16'h0000, 16'h6000, 16'd3, 0, 0, 0, 0, 5, 16'h0001, 11, 0, 11, 6, 3, 10, 1'b1, 16'h1111, 16'h2222, 16'h3333};
        vecs[1] = '{16'h0000, 16'h6080, 16'd0, 0, 0, 0, 0, 0, 16'h0000,  1, 0,  0, 0, 0,  0, 1'b0, 16'h0000, 16'h0000, 16'h0000};
        vecs[2] = '{16'h0000, 16'h6040, 16'd3, 2, 3, 0, 0, 4, 16'h0000, 13, 0, 13, 8, 3, 12, 1'b1, 16'h1111, 16'h2222, 16'h3333};
        vecs[3] = '{16'h0010, 16'h6100, 16'd3, 0, 0, 4, 6, 8, 16'h0011, 14, 0, 14, 6, 3, 13, 1'b1, 16'hAAAA, 16'hBBBB, 16'hCCCC};
`ifdef MEMORY_BUS_DMA_ROM_GUARD_EN
        vecs[4] = '{16'h0020, 16'h2000, 16'd2, 0, 0, 0, 0, 3, 16'h0020,  0, 3,  3, 1, 0,  2, 1'b0, 16'h0000, 16'h0000, 16'h0000};
`else
        vecs[4] = '{16'h0020, 16'h2000, 16'd2, 0, 0, 0, 0, 3, 16'h2000,  8, 0,  8, 4, 2,  7, 1'b0, 16'h0000, 16'h0000, 16'h0000};
`endif
        vecs[5] = '{16'hFFFF, 16'h6200, 16'd2, 0, 0, 0, 0, 5, 16'h0000,  8, 0,  8, 4, 2,  7, 1'b1, 16'hBEEF, 16'h1111, 16'h0000};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done_error", {done, error}, 0);
        check("reset_bus_request", bus_request, 0);
        check("reset_strobes", {bus_enable, write_enable}, 0);
        check("reset_address", address, 0);
        check("reset_data_out", bus_data_out, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int n = 0; n < 6; n++) run_vec(n, vecs[n]);

        // Reset during the second write of a wrapping copy
        @(negedge clk);
        src_addr = 16'hFFFF; dst_addr = 16'h6300; count = 16'd2; start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 5) check("wrap_second_read_addr", address, 16'h0000);
            if (k == 5) check("wrap_second_read_enable", {bus_enable, write_enable}, 2'b10);
        end
        check("second_write_address", address, 16'h6301);
        check("second_write_strobes", {bus_enable, write_enable}, 2'b11);
        reset = 1'b0;
        #1;
        check("async_reset_outputs", {busy, done, error, bus_request, bus_enable, write_enable}, 0);
        check("async_reset_address", address, 0);
        check("async_reset_data_out", bus_data_out, 0);
        dc = 0; ec = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            dc += int'(done); ec += int'(error);
            if (k == 1) reset = 1'b1;
        end
        check("post_reset_no_done", dc, 0);
        check("post_reset_no_error", ec, 0);
        check("post_reset_idle", {busy, bus_request, bus_enable}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/memory_bus_dma.md
# memory_bus_dma

Block-copy DMA initiator for the F100-L memory bus. It is the master-side counterpart to the bank router: it requests the bus from the CPU arbiter, then drives `address`, `bus_enable`, `write_enable` and write data into the router. It reads each word from a source address and writes it to a destination address, repeating for a programmed word count. It honours a `bus_ready` wait signal so slow banks (future SPI EEPROM) can stall it.

## Interface
- `ADDR_WIDTH`, 16, bus address width.
- `DATA_WIDTH`, 16, bus word width.

- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state and outputs immediately.
- `start` in 1: single-cycle launch strobe, sampled only in IDLE.
- `src_addr` in 16: first source word address, latched on start.
- `dst_addr` in 16: first destination word address, latched on start.
- `count` in 16: number of words to copy, latched on start.
- `busy` out 1: high from the cycle after start until DONE/ERROR is exited.
- `done` out 1: one-cycle pulse on successful completion.
- `error` out 1: one-cycle pulse on guarded abort (see Configuration).
- `bus_request` out 1: request to the CPU/DMA arbiter.
- `bus_grant` in 1: arbiter grant.
- `address` out 16: bus address.
- `bus_data_out` out 16: write data to the router `data_in`.
- `bus_data_in` in 16: read data from the router `data_out`.
- `bus_enable` out 1: access strobe.
- `write_enable` out 1: write qualifier; only ever high together with `bus_enable`.
- `bus_ready` in 1: access completes in any cycle where it is sampled high.

## Operation
- States: IDLE, REQUEST, READ, WRITE, NEXT, DONE, ERROR.
- IDLE: when `start`=1, latch `src_addr`, `dst_addr` and `count`. If `count`=0, go to DONE; otherwise go to REQUEST. A `start` in any other state is ignored.
- REQUEST: `bus_request`=1; all bus strobes low. Go to READ in the cycle after `bus_grant` is sampled high.
- READ: drive `address`=src and `bus_enable`=1. On the cycle `bus_ready`=1, capture `bus_data_in` into the holding register and go to WRITE. Otherwise hold the outputs and stay in READ.
- WRITE: drive `address`=dst, `bus_data_out`=held word, `bus_enable`=1 and `write_enable`=1. The write commits in the cycle `bus_ready`=1; then go to NEXT.
- NEXT: increment src and dst by 1, modulo 2^16 (0xFFFF wraps to 0x0000). Decrement the remaining count.
  - If remaining = 0, go to DONE.
  - Else if `bus_grant`=1, go to READ.
  - Else go to REQUEST (pause; `bus_request` stays high).
- The arbiter must not revoke `bus_grant` between READ and WRITE of one word. Grant is re-checked only in REQUEST and NEXT.
- DONE / ERROR: pulse `done` / `error` for one cycle, drop `bus_request` and `busy`, then return to IDLE.
- `bus_request` is high in REQUEST, READ, WRITE and NEXT.
- Reset mid-transfer abandons the copy. No completion pulse is issued. A partial write cannot occur, because the write strobe is deasserted asynchronously.

## Timing
- Reset values: all outputs 0, state IDLE, internal registers 0.
- With grant and ready held high, each word takes 3 cycles (READ, WRITE, NEXT).
- Start to `done` pulse for N≥1 words: 1 (REQUEST) + 3N + 1 cycles; `done` is asserted in cycle 3N+2 after the start edge.
- `count`=0: `done` is asserted in the cycle after start; no bus activity occurs.
- Each cycle `bus_ready` is low adds exactly one cycle to the current READ or WRITE.
- All outputs are registered; there is no combinational path from bus inputs to outputs.

## Configuration
- `MEMORY_BUS_DMA_ROM_GUARD_EN`: when defined, the block checks `dst` in the WRITE-entry cycle. If `address[14:13]`=2'b01 (the ROM bank), it goes to ERROR without asserting `write_enable`; the remaining words are abandoned.
- Undefined: ROM-bank writes are issued normally (the router drops them), and the transfer ends with `done`.

## Structure
- Shared package `f100l_bus_pkg`:
  - bank encodings BANK_RAM=2'b00, BANK_ROM=2'b01, BANK_PERIPH=2'b10, BANK_BLOCK_RAM=2'b11;
  - the DMA state enum;
  - the bank-select bit positions 14:13.
- Single module; no sub-module. The address and count registers are simple enough to inline.

## Test plan
- RAM 0x0000..0x0002 preloaded with 0x1111, 0x2222, 0x3333; src=0x0000, dst=0x6000, count=3; grant and ready tied high -> block RAM holds the same three words, `busy` is high for 11 cycles, `done` pulses on cycle 11.
- count=0 -> `done` on cycle 1, `bus_enable` never asserted, `busy` stays 0.
- `bus_ready` low for 2 cycles during the first READ -> `address` is held at src, and `done` arrives 2 cycles later than the baseline.
- `bus_grant` dropped in NEXT after word 1 of 3 -> `bus_enable` is 0 while grant is low, `bus_request` stays 1, the copy resumes on regrant, and the data is correct.
- dst=0x2000, count=2 -> with the macro: `error` pulses and `write_enable` is never 1. Without the macro: 2 write strobes are issued and `done` pulses.
- src=0xFFFF, count=2 -> the second read is at 0x0000. Assert `reset` low during the second WRITE -> all outputs are 0 immediately, with no `done` or `error` pulse.
